// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: owns the HD44780 {RS,RW,E,DATA} pins, runs power-up init, then timed writes.
// Define LCD_REQ_FIFO_EN to place a 4-entry request FIFO between the handshake and the sequencer.
module lcd_bus_sequencer #(
  parameter int E_PULSE_CYC      = 12,
  parameter int CMD_WAIT_CYC     = 2000,
  parameter int CLEAR_WAIT_CYC   = 82000,
  parameter int POWERUP_WAIT_CYC = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rs,
  input  logic [7:0]  req_data,
  output logic        init_done,
  output logic        busy,
  output logic [10:0] lcd_pins
);

  localparam int MAX_A = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_B = (CLEAR_WAIT_CYC > POWERUP_WAIT_CYC) ? CLEAR_WAIT_CYC : POWERUP_WAIT_CYC;
  localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_W) + 1;

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [2:0]       LAST_INIT  = 3'd5;

  typedef enum logic [2:0] {POWERUP, SETUP, E_HIGH, HOLD, IDLE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_rs, r_initDone;
  logic [7:0]       r_data;
  logic             w_isClear, w_holdDone, w_take, w_loadInit, w_advInit;
  logic             w_srcValid, w_srcRs;
  logic [7:0]       w_srcData, w_romByte;

  function automatic logic [7:0] initByte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: initByte = 8'h38;
      3'd3:             initByte = 8'h0C;
      3'd4:             initByte = 8'h01;
      default:          initByte = 8'h06;
    endcase
  endfunction

  // Clear and home need the long hold-off; decided from the byte currently on the pins.
  assign w_isClear  = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));
  assign w_holdDone = (r_cnt == (w_isClear ? CLEAR_LAST : CMD_LAST));
  assign w_romByte  = initByte(w_advInit ? (r_idx + 3'd1) : 3'd0);

  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_loadInit = 1'b0;
    w_advInit  = 1'b0;
    case (r_state)
      POWERUP: if (r_cnt == PWR_LAST) begin
        w_next     = SETUP;
        w_loadInit = 1'b1;
      end
      SETUP:   w_next = E_HIGH;
      E_HIGH:  if (r_cnt == E_LAST) w_next = HOLD;
      HOLD:    if (w_holdDone) begin
        if (!r_initDone && (r_idx != LAST_INIT)) begin
          w_next     = SETUP;
          w_loadInit = 1'b1;
          w_advInit  = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      IDLE:    if (w_srcValid) begin
        w_next = SETUP;
        w_take = 1'b1;
      end
      default: w_next = POWERUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= POWERUP;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_rs       <= 1'b0;
      r_data     <= 8'h00;
      r_initDone <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state != IDLE) r_cnt <= r_cnt + 1'b1;
      if (w_advInit) r_idx <= r_idx + 3'd1;
      if (w_loadInit) begin
        r_rs   <= 1'b0;
        r_data <= w_romByte;
      end else if (w_take) begin
        r_rs   <= w_srcRs;
        r_data <= w_srcData;
      end
      if ((r_state == HOLD) && (w_next == IDLE)) r_initDone <= 1'b1;
    end
  end

`ifdef LCD_REQ_FIFO_EN
  logic [8:0] r_mem [4];
  logic [1:0] r_wrPtr, r_rdPtr;
  logic [2:0] r_count;
  logic       w_push;

  assign req_ready  = (r_count != 3'd4);
  assign w_push     = req_valid && req_ready;
  assign w_srcValid = (r_count != 3'd0) && r_initDone;
  assign w_srcRs    = r_mem[r_rdPtr][8];
  assign w_srcData  = r_mem[r_rdPtr][7:0];
  assign busy       = (r_state != IDLE) || (r_count != 3'd0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= {req_rs, req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 2'd1;
      if (w_take) r_rdPtr <= r_rdPtr + 2'd1;
      if (w_push && !w_take) r_count <= r_count + 3'd1;
      else if (!w_push && w_take) r_count <= r_count - 3'd1;
    end
  end
`else
  assign req_ready  = (r_state == IDLE);
  assign w_srcValid = req_valid;
  assign w_srcRs    = req_rs;
  assign w_srcData  = req_data;
  assign busy       = (r_state != IDLE);
`endif

  assign init_done = r_initDone;
  assign lcd_pins  = {r_rs, 1'b0, (r_state == E_HIGH), r_data};

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer: randomized and directed writes checked every cycle against a timeline model.
// The model treats each write as a start edge plus a length and derives the pins from the offset.
module tb_lcd_bus_sequencer;

  localparam int EP  = 2;
  localparam int CW  = 5;
  localparam int CLW = 20;
  localparam int PW  = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_rs, init_done, busy;
  logic [7:0]  req_data;
  logic [10:0] lcd_pins;

  lcd_bus_sequencer #(
    .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW), .POWERUP_WAIT_CYC(PW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs),
    .req_data(req_data), .init_done(init_done), .busy(busy), .lcd_pins(lcd_pins)
  );

  initial forever #5 clk = ~clk;

  int vecCount = 0;
  int missCount = 0;
  bit checkEn = 1'b0;

  // Reference timeline: the current write began at edge mStart and occupies mLen edges.
  int       edgeCnt = 0;
  bit       mActive = 1'b0;
  int       mStart = 0;
  int       mLen = 0;
  bit       mRs = 1'b0;
  bit [7:0] mData = 8'h00;
  int       mInitIdx = 0;
  bit       mInitDone = 1'b0;
  bit [7:0] romInit [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [10:0] expInit [6] = '{11'h138, 11'h138, 11'h138, 11'h10C, 11'h101, 11'h106};
`ifdef LCD_REQ_FIFO_EN
  bit [8:0] mQ [$];
`endif

  logic [10:0] ePulses [$];
  int readyRiseEdge = -1;
  int doneEdge = -1;
  bit prevReady = 1'b0;
  bit prevDone = 1'b0;
  bit prevE = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  function automatic int holdOf(input bit rs, input bit [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CLW : CW;
  endfunction

  task automatic startWrite(input bit rs, input bit [7:0] d);
    mActive = 1'b1;
    mStart  = edgeCnt;
    mRs     = rs;
    mData   = d;
    mLen    = 1 + EP + holdOf(rs, d);
  endtask

  function automatic bit mReady();
`ifdef LCD_REQ_FIFO_EN
    return mQ.size() < 4;
`else
    return !mActive && mInitDone;
`endif
  endfunction

  function automatic bit mBusy();
`ifdef LCD_REQ_FIFO_EN
    return !(!mActive && mInitDone) || (mQ.size() > 0);
`else
    return !(!mActive && mInitDone);
`endif
  endfunction

  function automatic logic [10:0] expPins();
    int off;
    logic e;
    off = edgeCnt - mStart;
    e = mActive && (off >= 1) && (off <= EP);
    return {mRs, 1'b0, e, mData};
  endfunction

  task automatic modelStep();
    bit readyPrev;
`ifdef LCD_REQ_FIFO_EN
    bit idlePrev, doPop;
    bit [8:0] item;
`endif
    if (rst) begin
      edgeCnt = 0; mActive = 1'b0; mRs = 1'b0; mData = 8'h00;
      mInitIdx = 0; mInitDone = 1'b0;
`ifdef LCD_REQ_FIFO_EN
      mQ.delete();
`endif
      return;
    end
    readyPrev = mReady();
`ifdef LCD_REQ_FIFO_EN
    idlePrev = !mActive && mInitDone;
`endif
    edgeCnt++;
`ifdef LCD_REQ_FIFO_EN
    doPop = idlePrev && (mQ.size() > 0);
    item = 9'd0;
    if (doPop) item = mQ.pop_front();
    if (req_valid && readyPrev) mQ.push_back({req_rs, req_data});
`endif
    if (mActive && (edgeCnt == mStart + mLen)) begin
      mActive = 1'b0;
      if (!mInitDone) begin
        if (mInitIdx < 5) begin
          mInitIdx++;
          startWrite(1'b0, romInit[mInitIdx]);
        end else begin
          mInitDone = 1'b1;
        end
      end
    end else if (!mActive && !mInitDone && (edgeCnt == PW)) begin
      startWrite(1'b0, romInit[0]);
    end
`ifdef LCD_REQ_FIFO_EN
    else if (doPop) startWrite(item[8], item[7:0]);
`else
    else if (readyPrev && req_valid) startWrite(req_rs, req_data);
`endif
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    modelStep();
  end

  // Compare and event recording happen mid-cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      checkOutput("lcdPins", lcd_pins, expPins());
      checkOutput("reqReady", req_ready, mReady());
      checkOutput("initDone", init_done, mInitDone);
      checkOutput("busy", busy, mBusy());
    end
    if (req_ready && !prevReady) readyRiseEdge = edgeCnt;
    if (init_done && !prevDone) doneEdge = edgeCnt;
    if (lcd_pins[8] && !prevE) ePulses.push_back(lcd_pins);
    prevReady = req_ready;
    prevDone  = init_done;
    prevE     = lcd_pins[8];
  end

  // Holds the request until the DUT takes it; returns the edge number of the transfer.
  task automatic applyStimulus(input logic rs, input logic [7:0] data, output int accEdge);
    accEdge = -1;
    req_rs = rs;
    req_data = data;
    req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accEdge = edgeCnt + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (accEdge < 0) checkOutput("acceptTimeout", 0, 1);
  endtask

  task automatic waitInit();
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done) begin seen = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    if (!seen) checkOutput("initTimeout", 0, 1);
  endtask

  task automatic waitReady();
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin seen = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    if (!seen) checkOutput("readyTimeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin seen = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    if (!seen) checkOutput("idleTimeout", 0, 1);
  endtask

  task automatic checkInitPulses();
    checkOutput("initPulseCount", ePulses.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("initPulse%0d", i),
                  (i < ePulses.size()) ? 32'(ePulses[i]) : 32'hFFFF_FFFF, 32'(expInit[i]));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc, a1, a2, gap, sel, eCycles;
    logic rsR;
    logic [7:0] dR;
`ifdef LCD_REQ_FIFO_EN
    bit okArr [5];
    int okSum;
`endif
    req_valid = 1'b0;
    req_rs = 1'b0;
    req_data = 8'h00;
    #1 rst = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("resetPins", lcd_pins, 0);
    checkOutput("resetInitDone", init_done, 0);
    checkOutput("resetBusy", busy, 1);
`ifndef LCD_REQ_FIFO_EN
    checkOutput("resetReady", req_ready, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] power-up and init sequence");
`ifndef LCD_REQ_FIFO_EN
    applyStimulus(1'b1, 8'h55, acc);
    checkOutput("firstAcceptEdge", acc, 94);
`else
    waitInit();
`endif
    checkOutput("initDoneEdge", doneEdge, 93);
    checkInitPulses();

`ifndef LCD_REQ_FIFO_EN
    waitReady();
    $display("[TB] single data write and clear/home hold-off");
    applyStimulus(1'b1, 8'h41, acc);
    @(negedge clk);
    checkOutput("setupPins", lcd_pins, 11'h441);
    waitReady();
    checkOutput("dataReadyDelay", readyRiseEdge - acc, 8);
    checkOutput("dataPinsHeld", lcd_pins, 11'h441);

    applyStimulus(1'b0, 8'h01, a1);
    applyStimulus(1'b0, 8'h80, a2);
    checkOutput("clearReadyDelay", readyRiseEdge - a1, 23);
    waitReady();
    applyStimulus(1'b0, 8'h02, a1);
    applyStimulus(1'b0, 8'h80, a2);
    checkOutput("homeReadyDelay", readyRiseEdge - a1, 23);
    waitReady();
`endif

    $display("[TB] reset during E pulse");
    applyStimulus(1'b1, 8'h5A, acc);
    eCycles = 0;
    while (!lcd_pins[8] && eCycles < 50) begin
      @(negedge clk);
      eCycles++;
    end
    checkOutput("eHighReached", lcd_pins[8], 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("abortPins", lcd_pins, 0);
    checkOutput("abortInitDone", init_done, 0);
    ePulses.delete();
    doneEdge = -1;
    @(negedge clk);
    rst = 1'b0;
    waitInit();
    checkOutput("reinitDoneEdge", doneEdge, 93);
    checkInitPulses();

    $display("[TB] randomized writes");
    for (int k = 0; k < 40; k++) begin
      gap = $urandom_range(0, 4);
      sel = $urandom_range(0, 7);
      rsR = 1'($urandom_range(0, 1));
      dR  = 8'($urandom);
      if (sel == 0) begin rsR = 1'b0; dR = 8'h01; end
      else if (sel == 1) begin rsR = 1'b0; dR = 8'h02; end
      repeat (gap) @(posedge clk);
      #1;
      applyStimulus(rsR, dR, acc);
    end
    waitIdle();

`ifdef LCD_REQ_FIFO_EN
    $display("[TB] FIFO fill during power-up");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ePulses.delete();
    doneEdge = -1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    okSum = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_rs = 1'b1;
      req_data = 8'hA0 + 8'(i);
      @(negedge clk);
      okArr[i] = req_ready;
      okSum += int'(req_ready);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    checkOutput("fifoAccepted", okSum, 4);
    checkOutput("fifoFullReady", okArr[4], 0);
    waitInit();
    waitIdle();
    checkOutput("fifoPulseCount", ePulses.size(), 10);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("fifoPulse%0d", i),
                  (6 + i < ePulses.size()) ? 32'(ePulses[6 + i]) : 32'hFFFF_FFFF,
                  32'h5A0 + 32'(i));
`endif

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
